// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// fir_seq_ctrl : sample sequencer and double-banked coefficient manager for
//                the 8-tap FIR datapath. Optional FLUSH via FIR_FLUSH_EN.
// Revision     : 1.0
// ============================================================================
module fir_seq_ctrl #(
    parameter int DW      = 16,
    parameter int NTAP    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [15:0]   cfg_wdata,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    output logic          bank_sel,
    output logic [15:0]   coef0,
    output logic [15:0]   coef1,
    output logic [15:0]   coef2,
    output logic [15:0]   coef3,
    output logic [15:0]   coef4,
    output logic [15:0]   coef5,
    output logic [15:0]   coef6,
    output logic [15:0]   coef7,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] f_data_in,
    output logic          f_data_in_ready,
    input  logic [DW-1:0] f_data_out,
    input  logic          f_data_out_flag,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          err_timeout
);

    localparam int AW = $clog2(NTAP);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    c_ntap    = 4'(NTAP);
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;
`ifdef FIR_FLUSH_EN
    localparam logic [1:0] c_st_flush  = 2'd3;
    localparam logic [1:0] c_st_commit = c_st_flush;
`else
    localparam logic [1:0] c_st_commit = c_st_idle;
`endif

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [NTAP-1:0][15:0]     r_shadow;
    logic [NTAP-1:0][15:0]     r_active;
    logic                      r_bank_sel;
    logic                      r_commit_pend;
    logic [TW-1:0]             r_timer;
    logic                      r_strobe;
    logic [DW-1:0]             r_f_data_in;
    logic                      r_m_valid;
    logic [DW-1:0]             r_m_data;
    logic                      r_err;

    logic w_tmo_hit;
    logic w_apply;
    logic w_accept;
    logic w_capture;
    logic w_release;
    logic w_tmo;
    logic w_timer_run;
    logic w_in_flush;
    logic w_fl_strobe;

`ifdef FIR_FLUSH_EN
    logic          r_fl_wait;
    logic [AW-1:0] r_fl_cnt;
    logic          w_fl_step;
    logic          w_fl_last;
`endif

    assign w_tmo_hit = (r_timer == c_timeout);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a pending commit always beats a new sample in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_commit_pend) begin
                    w_state_nxt = c_st_commit;
                end else if (s_valid) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (f_data_out_flag) begin
                    w_state_nxt = c_st_hold;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_hold: begin
                if (m_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
`ifdef FIR_FLUSH_EN
            c_st_flush: begin
                if (w_fl_step && w_fl_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
`endif
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_apply     = (r_state == c_st_idle) && r_commit_pend;
        w_accept    = (r_state == c_st_idle) && !r_commit_pend && s_valid;
        w_capture   = (r_state == c_st_wait) && f_data_out_flag;
        w_release   = (r_state == c_st_hold) && m_ready;
        w_tmo       = (r_state == c_st_wait) && !f_data_out_flag && w_tmo_hit;
        w_timer_run = (r_state == c_st_wait);
        w_in_flush  = 1'b0;
        w_fl_strobe = 1'b0;
`ifdef FIR_FLUSH_EN
        w_in_flush  = (r_state == c_st_flush);
        w_fl_strobe = w_in_flush && !r_fl_wait;
        w_fl_step   = w_in_flush && r_fl_wait && (f_data_out_flag || w_tmo_hit);
        w_fl_last   = (r_fl_cnt == AW'(NTAP - 1));
        if (w_in_flush && r_fl_wait) begin
            w_timer_run = 1'b1;
            if (!f_data_out_flag && w_tmo_hit) begin
                w_tmo = 1'b1;
            end
        end
`endif
        s_ready  = (r_state == c_st_idle) && !r_commit_pend;
        cfg_busy = r_commit_pend || w_in_flush;
    end

`ifdef FIR_FLUSH_EN
    // Flush walks NTAP strobe/flag pairs; results are never captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fl_wait <= 1'b0;
            r_fl_cnt  <= '0;
        end else if (w_apply) begin
            r_fl_wait <= 1'b0;
            r_fl_cnt  <= '0;
        end else if (w_fl_strobe) begin
            r_fl_wait <= 1'b1;
        end else if (w_fl_step) begin
            r_fl_wait <= 1'b0;
            r_fl_cnt  <= r_fl_cnt + AW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_bank_sel    <= 1'b0;
            r_commit_pend <= 1'b0;
            r_timer       <= '0;
            r_strobe      <= 1'b0;
            r_f_data_in   <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_err         <= 1'b0;
        end else begin
            if (cfg_we && (cfg_addr < c_ntap)) begin
                r_shadow[cfg_addr[AW-1:0]] <= cfg_wdata;
            end
            if (w_apply) begin
                r_active   <= r_shadow;
                r_bank_sel <= ~r_bank_sel;
            end
            // A commit arriving while one is pending simply keeps it pending
            r_commit_pend <= cfg_commit || (r_commit_pend && !w_apply);
            r_strobe      <= w_accept || w_fl_strobe;
            if (w_accept) begin
                r_f_data_in <= s_data;
            end else if (w_fl_strobe) begin
                r_f_data_in <= '0;
            end
            if (w_accept || w_fl_strobe) begin
                r_timer <= '0;
            end else if (w_timer_run) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_capture) begin
                r_m_data  <= f_data_out;
                r_m_valid <= 1'b1;
            end else if (w_release) begin
                r_m_valid <= 1'b0;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bank_sel        = r_bank_sel;
    assign f_data_in       = r_f_data_in;
    assign f_data_in_ready = r_strobe;
    assign m_valid         = r_m_valid;
    assign m_data          = r_m_data;
    assign err_timeout     = r_err;
    assign coef0           = r_active[0];
    assign coef1           = r_active[1];
    assign coef2           = r_active[2];
    assign coef3           = r_active[3];
    assign coef4           = r_active[4];
    assign coef5           = r_active[5];
    assign coef6           = r_active[6];
    assign coef7           = r_active[7];

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fir_seq_ctrl : directed bench for fir_seq_ctrl with a delayed FIR stub.
// Revision        : 1.0
// ============================================================================
module tb_fir_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_commit;
    logic        cfg_busy;
    logic        bank_sel;
    logic [15:0] coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [15:0] f_data_in;
    logic        f_data_in_ready;
    logic [15:0] f_data_out;
    logic        f_data_out_flag;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        err_timeout;

    logic [7:0][15:0] coefs_w;
    logic [7:0][15:0] hist;
    logic [15:0]      y_pend;
    logic [2:0]       cd;
    logic             suppress;

    int n_checks = 0;
    int n_errors = 0;

    assign coefs_w = {coef7, coef6, coef5, coef4, coef3, coef2, coef1, coef0};

    always #5 clk = ~clk;

    fir_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .bank_sel(bank_sel),
        .coef0(coef0), .coef1(coef1), .coef2(coef2), .coef3(coef3),
        .coef4(coef4), .coef5(coef5), .coef6(coef6), .coef7(coef7),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .f_data_in(f_data_in), .f_data_in_ready(f_data_in_ready),
        .f_data_out(f_data_out), .f_data_out_flag(f_data_out_flag),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_timeout(err_timeout)
    );

    function automatic logic [15:0] fir(input logic [15:0] x,
                                        input logic [7:0][15:0] h,
                                        input logic [7:0][15:0] c);
        logic [31:0] acc;
        acc = 32'(x) * 32'(c[0][8:0]);
        for (int k = 1; k < 8; k++) begin
            acc = acc + 32'(h[k-1]) * 32'(c[k][8:0]);
        end
        return acc[15:0];
    endfunction

    // Filter stub: flag arrives four cycles after the strobe is seen
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist            <= '0;
            y_pend          <= '0;
            cd              <= '0;
            f_data_out      <= '0;
            f_data_out_flag <= 1'b0;
        end else begin
            f_data_out_flag <= 1'b0;
            if (f_data_in_ready) begin
                hist   <= {hist[6:0], f_data_in};
                y_pend <= fir(f_data_in, hist, coefs_w);
                cd     <= 3'd3;
            end else if (cd != 3'd0) begin
                cd <= cd - 3'd1;
                if (cd == 3'd1 && !suppress) begin
                    f_data_out_flag <= 1'b1;
                    f_data_out      <= y_pend;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        s_valid = 1'b0;
        check_eq("accept", 32'(ok), 32'd1);
        check_eq("strobe", 32'(f_data_in_ready), 32'd1);
        check_eq("f_data_in", 32'(f_data_in), 32'(d));
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp);
        bit seen = 1'b0;
        int strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (f_data_in_ready) strobes++;
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_valid"}, 32'(seen), 32'd1);
        check_eq({tag, "_data"}, 32'(m_data), 32'(exp));
        check_eq({tag, "_extra_strobe"}, 32'(strobes), 32'd0);
    endtask

    task automatic consume();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq("consumed", 32'(m_valid), 32'd0);
    endtask

    // Called on the first negedge after a commit has been applied
    task automatic commit_settle();
`ifdef FIR_FLUSH_EN
        int strobes = 0;
        int nonzero = 0;
        int mv = 0;
        for (int i = 0; i < 400; i++) begin
            if (!cfg_busy) break;
            if (f_data_in_ready) begin
                strobes++;
                if (f_data_in != 16'h0) nonzero++;
            end
            if (m_valid) mv++;
            @(negedge clk);
        end
        check_eq("flush_done", 32'(cfg_busy), 32'd0);
        check_eq("flush_strobes", 32'(strobes), 32'd8);
        check_eq("flush_data_zero", 32'(nonzero), 32'd0);
        check_eq("flush_no_mvalid", 32'(mv), 32'd0);
`endif
        check_eq("settle_busy", 32'(cfg_busy), 32'd0);
        check_eq("settle_s_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        int bad;
        logic [15:0] exp3;
`ifdef FIR_FLUSH_EN
        exp3 = 16'h000A;
`else
        exp3 = 16'h0515;
`endif
        reset      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_commit = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        suppress   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_coef0", 32'(coef0), 32'd0);
        check_eq("rst_coef7", 32'(coef7), 32'd0);
        check_eq("rst_bank", 32'(bank_sel), 32'd0);
        check_eq("rst_mvalid", 32'(m_valid), 32'd0);
        check_eq("rst_strobe", 32'(f_data_in_ready), 32'd0);
        check_eq("rst_busy", 32'(cfg_busy), 32'd0);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Load shadow 1..8 plus an out-of-range write that must be ignored
        for (int k = 0; k < 8; k++) begin
            cfg_we = 1'b1; cfg_addr = 4'(k); cfg_wdata = 16'(k + 1);
            @(negedge clk);
        end
        cfg_addr = 4'd9; cfg_wdata = 16'hFFFF;
        @(negedge clk);
        cfg_we = 1'b0;
        check_eq("shadow_no_disturb", 32'(coef0), 32'd0);
        check_eq("shadow_bank", 32'(bank_sel), 32'd0);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check_eq("commit_busy", 32'(cfg_busy), 32'd1);
        check_eq("commit_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("coef%0d", k), 32'(coefs_w[k]), 32'(k + 1));
        end
        check_eq("bank_after_commit", 32'(bank_sel), 32'd1);
        commit_settle();

        // First sample, then back-pressure for 20 cycles
        send(16'h0100);
        wait_result("r0", 16'h0100);
        s_valid = 1'b1;
        s_data  = 16'h0002;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!m_valid || m_data != 16'h0100 || s_ready || f_data_in_ready) bad++;
        end
        check_eq("hold_stable", 32'(bad), 32'd0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq("release_mvalid", 32'(m_valid), 32'd0);
        check_eq("release_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check_eq("r1_strobe", 32'(f_data_in_ready), 32'd1);
        check_eq("r1_f_data_in", 32'(f_data_in), 32'h0002);
        wait_result("r1", 16'h0202);
        consume();

        // Commit while a sample is in flight
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'd3;
        @(negedge clk);
        cfg_we = 1'b0;
        send(16'h0001);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check_eq("wait_commit_busy", 32'(cfg_busy), 32'd1);
        check_eq("wait_commit_coef0", 32'(coef0), 32'd1);
        wait_result("r2", 16'h0305);
        check_eq("hold_coef0", 32'(coef0), 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq("pend_s_ready", 32'(s_ready), 32'd0);
        check_eq("pend_coef0", 32'(coef0), 32'd1);
        @(negedge clk);
        check_eq("swap_coef0", 32'(coef0), 32'd3);
        check_eq("swap_bank", 32'(bank_sel), 32'd0);
        commit_settle();

        // Suppressed flag: timeout after 16 WAIT edges
        suppress = 1'b1;
        send(16'h0005);
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (m_valid) bad++;
        end
        check_eq("tmo_early", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check_eq("tmo_err", 32'(err_timeout), 32'd1);
        check_eq("tmo_idle", 32'(s_ready), 32'd1);
        check_eq("tmo_no_mvalid", 32'(bad + int'(m_valid)), 32'd0);
        suppress = 1'b0;
        send(16'h0000);
        wait_result("r3", exp3);
        consume();
        check_eq("err_sticky", 32'(err_timeout), 32'd1);

        // Asynchronous reset in the middle of a transaction
        send(16'h0007);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_mvalid", 32'(m_valid), 32'd0);
        check_eq("mid_rst_strobe", 32'(f_data_in_ready), 32'd0);
        check_eq("mid_rst_coef0", 32'(coef0), 32'd0);
        check_eq("mid_rst_err", 32'(err_timeout), 32'd0);
        check_eq("mid_rst_busy", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_s_ready", 32'(s_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
